// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Hardwired Moore sequencer for the single-issue CPU datapath. Walks each
// instruction through fetch (T0-T3), decode (T4) and execute (T5-T9), and
// drives every register enable, memory strobe, bus driver and ALU opcode.
//
// Ports:
//   clk                  system clock, rising-edge active
//   clr                  asynchronous active-low reset
//   IR_Data[31:0]        current instruction, opcode in [31:27]
//   con_output           branch condition from the datapath
//   stop                 pause request, honoured only when entering T0
//   run                  high unless halted (or held in reset)
//   illegal_op           single-cycle flag in T4 for opcodes 11100-11111
//   *_enable             register load enables
//   read, write          memory strobes
//   Gra/Grb/Grc, r_enable, r_select, BAout   register-file select/encode
//   *_select             bus drivers (at most one active per state)
//   alu_instruction[4:0] ALU opcode
// ---------------------------------------------------------------------------
module control_unit #(
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [31:0] IR_Data,
    input  logic       con_output,
    input  logic       stop,
    output logic       run,
    output logic       illegal_op,
    output logic       PC_enable,
    output logic       PC_increment_enable,
    output logic       IR_enable,
    output logic       con_enable,
    output logic       Y_enable,
    output logic       Z_enable,
    output logic       MAR_enable,
    output logic       MDR_enable,
    output logic       HI_enable,
    output logic       LO_enable,
    output logic       manual_R15_enable,
    output logic       read,
    output logic       write,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       r_enable,
    output logic       r_select,
    output logic       BAout,
    output logic       PC_select,
    output logic       HI_select,
    output logic       LO_select,
    output logic       Z_HI_select,
    output logic       Z_LO_select,
    output logic       MDR_select,
    output logic       InPort_select,
    output logic       c_select,
    output logic [4:0] alu_instruction
);

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, T8, T9, PAUSE, HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BRX  = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state, next_state, last_state, fetch_entry;
    logic       started;
    logic [4:0] opcode;
    logic       is_rtype, is_imm;
    logic [4:0] imm_alu;
    logic       unused_ir_bits;

    assign opcode         = IR_Data[31:27];
    assign unused_ir_bits = ^IR_Data[26:0];
    assign is_rtype       = (opcode >= OP_ADD) && (opcode <= OP_SHL);
    assign is_imm         = (opcode >= OP_ADDI) && (opcode <= OP_ORI);

    // Immediate forms reuse the ALU opcode of their register counterpart.
    always_comb begin
        imm_alu = ADD_OP;
        if (opcode == OP_ANDI) imm_alu = OP_AND;
        if (opcode == OP_ORI)  imm_alu = OP_OR;
    end

    // started stays low until the first edge after reset release, so the
    // reset state (T0) does not present fetch outputs before T0 is entered.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= T0;
            started <= 1'b0;
        end else begin
            state   <= next_state;
            started <= 1'b1;
        end
    end

    // Final execute state of each instruction class.
    always_comb begin
        last_state = T4;
        if (is_rtype || is_imm) last_state = T6;
        else begin
            case (opcode)
                OP_NEG, OP_NOT, OP_JAL: last_state = T5;
                OP_DIV, OP_MUL, OP_BRX: last_state = T7;
                OP_LDI:                 last_state = T6;
                OP_LD:                  last_state = T9;
                OP_ST:                  last_state = T8;
                default:                last_state = T4;
            endcase
        end
    end

    assign fetch_entry = stop ? PAUSE : T0;

    always_comb begin
        next_state = state;
        if (!started) begin
            next_state = fetch_entry;
        end else begin
            case (state)
                T0:    next_state = T1;
                T1:    next_state = T2;
                T2:    next_state = T3;
                T3:    next_state = T4;
                PAUSE: next_state = stop ? PAUSE : T0;
                HALT:  next_state = HALT;
                default: begin
                    if (state == T4 && opcode == OP_HALT) begin
                        next_state = HALT;
                    end else if (state == last_state) begin
                        next_state = fetch_entry;
                    end else begin
                        case (state)
                            T4:      next_state = T5;
                            T5:      next_state = T6;
                            T6:      next_state = T7;
                            T7:      next_state = T8;
                            T8:      next_state = T9;
                            default: next_state = fetch_entry;
                        endcase
                    end
                end
            endcase
        end
    end

    // run reflects clr directly so it rises as soon as reset is released.
    assign run = clr && (state != HALT);

    always_comb begin
        illegal_op = 1'b0;  PC_enable = 1'b0;  PC_increment_enable = 1'b0;
        IR_enable = 1'b0;   con_enable = 1'b0; Y_enable = 1'b0;
        Z_enable = 1'b0;    MAR_enable = 1'b0; MDR_enable = 1'b0;
        HI_enable = 1'b0;   LO_enable = 1'b0;  manual_R15_enable = 1'b0;
        read = 1'b0;        write = 1'b0;      Gra = 1'b0;
        Grb = 1'b0;         Grc = 1'b0;        r_enable = 1'b0;
        r_select = 1'b0;    BAout = 1'b0;      PC_select = 1'b0;
        HI_select = 1'b0;   LO_select = 1'b0;  Z_HI_select = 1'b0;
        Z_LO_select = 1'b0; MDR_select = 1'b0; InPort_select = 1'b0;
        c_select = 1'b0;    alu_instruction = 5'b00000;

        if (started) begin
            case (state)
                T0: begin PC_select = 1'b1; MAR_enable = 1'b1; PC_increment_enable = 1'b1; end
                T1: read = 1'b1;
                T2: begin read = 1'b1; MDR_enable = 1'b1; end
                T3: begin MDR_select = 1'b1; IR_enable = 1'b1; end
                T4, T5, T6, T7, T8, T9: begin
                    if (is_rtype || is_imm) begin
                        case (state)
                            T4: begin Grb = 1'b1; r_select = 1'b1; Y_enable = 1'b1; end
                            T5: begin
                                Z_enable = 1'b1;
                                if (is_imm) begin
                                    c_select = 1'b1; alu_instruction = imm_alu;
                                end else begin
                                    Grc = 1'b1; r_select = 1'b1; alu_instruction = opcode;
                                end
                            end
                            T6: begin Z_LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1; end
                            default: ;
                        endcase
                    end else begin
                        case (opcode)
                            OP_NEG, OP_NOT: case (state)
                                T4: begin Grb = 1'b1; r_select = 1'b1; alu_instruction = opcode; Z_enable = 1'b1; end
                                T5: begin Z_LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1; end
                                default: ;
                            endcase
                            OP_DIV, OP_MUL: case (state)
                                T4: begin Gra = 1'b1; r_select = 1'b1; Y_enable = 1'b1; end
                                T5: begin Grb = 1'b1; r_select = 1'b1; alu_instruction = opcode; Z_enable = 1'b1; end
                                T6: begin Z_LO_select = 1'b1; LO_enable = 1'b1; end
                                T7: begin Z_HI_select = 1'b1; HI_enable = 1'b1; end
                                default: ;
                            endcase
                            OP_LD, OP_LDI, OP_ST: case (state)
                                T4: begin Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1; end
                                T5: begin c_select = 1'b1; alu_instruction = ADD_OP; Z_enable = 1'b1; end
                                T6: begin
                                    Z_LO_select = 1'b1;
                                    if (opcode == OP_LDI) begin
                                        Gra = 1'b1; r_enable = 1'b1;
                                    end else begin
                                        MAR_enable = 1'b1;
                                    end
                                end
                                T7: begin
                                    if (opcode == OP_ST) begin
                                        Gra = 1'b1; r_select = 1'b1; MDR_enable = 1'b1;
                                    end else begin
                                        read = 1'b1;
                                    end
                                end
                                T8: begin
                                    if (opcode == OP_ST) begin
                                        write = 1'b1;
                                    end else begin
                                        read = 1'b1; MDR_enable = 1'b1;
                                    end
                                end
                                T9: begin MDR_select = 1'b1; Gra = 1'b1; r_enable = 1'b1; end
                                default: ;
                            endcase
                            OP_BRX: case (state)
                                T4: begin Gra = 1'b1; r_select = 1'b1; con_enable = 1'b1; end
                                T5: begin PC_select = 1'b1; Y_enable = 1'b1; end
                                T6: begin c_select = 1'b1; alu_instruction = ADD_OP; Z_enable = 1'b1; end
                                T7: begin
                                    // Branch not taken leaves the PC alone.
                                    if (con_output) begin
                                        Z_LO_select = 1'b1; PC_enable = 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                            OP_JR: if (state == T4) begin
                                Gra = 1'b1; r_select = 1'b1; PC_enable = 1'b1;
                            end
                            OP_JAL: case (state)
                                T4: begin PC_select = 1'b1; manual_R15_enable = 1'b1; end
                                T5: begin Gra = 1'b1; r_select = 1'b1; PC_enable = 1'b1; end
                                default: ;
                            endcase
                            OP_MFHI: if (state == T4) begin
                                HI_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
                            end
                            OP_MFLO: if (state == T4) begin
                                LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
                            end
                            OP_IN: if (state == T4) begin
                                InPort_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
                            end
                            default: if (state == T4 && opcode[4:2] == 3'b111) begin
                                illegal_op = 1'b1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    typedef logic [33:0] vec_t;

    localparam vec_t RUN    = 34'd1 << 28;
    localparam vec_t ILL    = 34'd1 << 27;
    localparam vec_t PC_EN  = 34'd1 << 26;
    localparam vec_t PCI_EN = 34'd1 << 25;
    localparam vec_t IR_EN  = 34'd1 << 24;
    localparam vec_t CON_EN = 34'd1 << 23;
    localparam vec_t Y_EN   = 34'd1 << 22;
    localparam vec_t Z_EN   = 34'd1 << 21;
    localparam vec_t MAR_EN = 34'd1 << 20;
    localparam vec_t MDR_EN = 34'd1 << 19;
    localparam vec_t HI_EN  = 34'd1 << 18;
    localparam vec_t LO_EN  = 34'd1 << 17;
    localparam vec_t R15_EN = 34'd1 << 16;
    localparam vec_t RD     = 34'd1 << 15;
    localparam vec_t WR     = 34'd1 << 14;
    localparam vec_t GRA    = 34'd1 << 13;
    localparam vec_t GRB    = 34'd1 << 12;
    localparam vec_t GRC    = 34'd1 << 11;
    localparam vec_t R_EN   = 34'd1 << 10;
    localparam vec_t R_SEL  = 34'd1 << 9;
    localparam vec_t BAOUT  = 34'd1 << 8;
    localparam vec_t PC_SEL = 34'd1 << 7;
    localparam vec_t HI_SEL = 34'd1 << 6;
    localparam vec_t LO_SEL = 34'd1 << 5;
    localparam vec_t ZHI    = 34'd1 << 4;
    localparam vec_t ZLO    = 34'd1 << 3;
    localparam vec_t MDR_SEL= 34'd1 << 2;
    localparam vec_t IN_SEL = 34'd1 << 1;
    localparam vec_t C_SEL  = 34'd1 << 0;

    logic clk, clr, con_output, stop;
    logic [31:0] IR_Data;
    logic run, illegal_op, PC_enable, PC_increment_enable, IR_enable, con_enable;
    logic Y_enable, Z_enable, MAR_enable, MDR_enable, HI_enable, LO_enable;
    logic manual_R15_enable, read, write, Gra, Grb, Grc, r_enable, r_select, BAout;
    logic PC_select, HI_select, LO_select, Z_HI_select, Z_LO_select, MDR_select;
    logic InPort_select, c_select;
    logic [4:0] alu_instruction;

    control_unit dut (
        .clk(clk), .clr(clr), .IR_Data(IR_Data), .con_output(con_output), .stop(stop),
        .run(run), .illegal_op(illegal_op), .PC_enable(PC_enable),
        .PC_increment_enable(PC_increment_enable), .IR_enable(IR_enable),
        .con_enable(con_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
        .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .HI_enable(HI_enable),
        .LO_enable(LO_enable), .manual_R15_enable(manual_R15_enable),
        .read(read), .write(write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .r_enable(r_enable), .r_select(r_select), .BAout(BAout),
        .PC_select(PC_select), .HI_select(HI_select), .LO_select(LO_select),
        .Z_HI_select(Z_HI_select), .Z_LO_select(Z_LO_select),
        .MDR_select(MDR_select), .InPort_select(InPort_select),
        .c_select(c_select), .alu_instruction(alu_instruction)
    );

    // 10 ns clock; stimulus lands 1 ns after the rising edge, checks on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    logic [31:0] ir_v;
    logic        clr_v, stop_v, con_v;

    function automatic vec_t alu(input logic [4:0] op);
        alu = {op, 29'd0};
    endfunction

    function automatic vec_t actual_vec();
        actual_vec = {alu_instruction, run, illegal_op, PC_enable, PC_increment_enable,
                      IR_enable, con_enable, Y_enable, Z_enable, MAR_enable, MDR_enable,
                      HI_enable, LO_enable, manual_R15_enable, read, write, Gra, Grb,
                      Grc, r_enable, r_select, BAout, PC_select, HI_select, LO_select,
                      Z_HI_select, Z_LO_select, MDR_select, InPort_select, c_select};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected for that cycle.
    task automatic applyStimulus(input string tag, input vec_t expv);
        @(posedge clk);
        #1;
        IR_Data    = ir_v;
        clr        = clr_v;
        stop       = stop_v;
        con_output = con_v;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
    endtask

    task automatic checkOutput(input string tag, input vec_t expv);
        vec_t act;
        act = actual_vec();
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, expv);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(tag_q.pop_front(), exp_q.pop_front());
        end
    end

    task automatic fetch(input string name);
        applyStimulus({name, "_T0"}, RUN | PC_SEL | MAR_EN | PCI_EN);
        applyStimulus({name, "_T1"}, RUN | RD);
        applyStimulus({name, "_T2"}, RUN | RD | MDR_EN);
        applyStimulus({name, "_T3"}, RUN | MDR_SEL | IR_EN);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        clr   = 1'b1;
        clr_v = 1'b1;
    endtask

    initial begin
        clr = 1'b0; stop = 1'b0; con_output = 1'b0; IR_Data = 32'd0;
        clr_v = 1'b0; stop_v = 1'b0; con_v = 1'b0; ir_v = 32'd0;

        for (int i = 0; i < 3; i++) applyStimulus("reset", 34'd0);
        release_reset();

        // add r3,r1,r2
        ir_v = 32'h19890000;
        fetch("add");
        applyStimulus("add_T4", RUN | GRB | R_SEL | Y_EN);
        applyStimulus("add_T5", RUN | GRC | R_SEL | Z_EN | alu(5'b00011));
        applyStimulus("add_T6", RUN | ZLO | GRA | R_EN);

        // ld with stop raised mid-instruction, then PAUSE
        ir_v = 32'h00800014;
        fetch("ld");
        applyStimulus("ld_T4", RUN | GRB | BAOUT | Y_EN);
        stop_v = 1'b1;
        applyStimulus("ld_T5", RUN | C_SEL | Z_EN | alu(5'b00011));
        applyStimulus("ld_T6", RUN | ZLO | MAR_EN);
        applyStimulus("ld_T7", RUN | RD);
        applyStimulus("ld_T8", RUN | RD | MDR_EN);
        applyStimulus("ld_T9", RUN | MDR_SEL | GRA | R_EN);
        applyStimulus("pause0", RUN);
        applyStimulus("pause1", RUN);
        stop_v = 1'b0;
        applyStimulus("pause2", RUN);

        // brx not taken, then taken
        ir_v = 32'h98000000;
        for (int taken = 0; taken < 2; taken++) begin
            con_v = taken[0];
            fetch("brx");
            applyStimulus("brx_T4", RUN | GRA | R_SEL | CON_EN);
            applyStimulus("brx_T5", RUN | PC_SEL | Y_EN);
            applyStimulus("brx_T6", RUN | C_SEL | Z_EN | alu(5'b00011));
            applyStimulus("brx_T7", taken == 1 ? (RUN | ZLO | PC_EN) : RUN);
        end
        con_v = 1'b0;

        // mul
        ir_v = 32'h80000000;
        fetch("mul");
        applyStimulus("mul_T4", RUN | GRA | R_SEL | Y_EN);
        applyStimulus("mul_T5", RUN | GRB | R_SEL | Z_EN | alu(5'b10000));
        applyStimulus("mul_T6", RUN | ZLO | LO_EN);
        applyStimulus("mul_T7", RUN | ZHI | HI_EN);

        // andi uses the 'and' ALU opcode with the constant on the bus
        ir_v = 32'h68000000;
        fetch("andi");
        applyStimulus("andi_T4", RUN | GRB | R_SEL | Y_EN);
        applyStimulus("andi_T5", RUN | C_SEL | Z_EN | alu(5'b00101));
        applyStimulus("andi_T6", RUN | ZLO | GRA | R_EN);

        // neg
        ir_v = 32'h88000000;
        fetch("neg");
        applyStimulus("neg_T4", RUN | GRB | R_SEL | Z_EN | alu(5'b10001));
        applyStimulus("neg_T5", RUN | ZLO | GRA | R_EN);

        // jr, jal, mfhi, in, nop
        ir_v = 32'hA0000000;
        fetch("jr");
        applyStimulus("jr_T4", RUN | GRA | R_SEL | PC_EN);
        ir_v = 32'hA8000000;
        fetch("jal");
        applyStimulus("jal_T4", RUN | PC_SEL | R15_EN);
        applyStimulus("jal_T5", RUN | GRA | R_SEL | PC_EN);
        ir_v = 32'hC0000000;
        fetch("mfhi");
        applyStimulus("mfhi_T4", RUN | HI_SEL | GRA | R_EN);
        ir_v = 32'hB0000000;
        fetch("in");
        applyStimulus("in_T4", RUN | IN_SEL | GRA | R_EN);
        ir_v = 32'hD0000000;
        fetch("nop");
        applyStimulus("nop_T4", RUN);

        // illegal opcode 11110
        ir_v = 32'hF0000000;
        fetch("illegal");
        applyStimulus("illegal_T4", RUN | ILL);

        // st aborted by reset in T8
        ir_v = 32'h10000000;
        fetch("st");
        applyStimulus("st_T4", RUN | GRB | BAOUT | Y_EN);
        applyStimulus("st_T5", RUN | C_SEL | Z_EN | alu(5'b00011));
        applyStimulus("st_T6", RUN | ZLO | MAR_EN);
        applyStimulus("st_T7", RUN | GRA | R_SEL | MDR_EN);
        clr_v = 1'b0;
        applyStimulus("st_T8_reset", 34'd0);
        applyStimulus("st_reset1", 34'd0);
        applyStimulus("st_reset2", 34'd0);
        release_reset();

        // halt: run drops after T4 and stays low, stop has no effect
        ir_v = 32'hD8000000;
        fetch("halt");
        applyStimulus("halt_T4", RUN);
        for (int i = 0; i < 20; i++) begin
            stop_v = i[1];
            applyStimulus("halted", 34'd0);
        end

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the bench always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
